// File: rtl/ntt_sched_pkg.sv
// ntt_sched_pkg -- shared types and constants for the NTT memory scheduler.
//   WID     : coefficient width
//   AWID    : coefficient-RAM address width (128 coefficients)
//   NLAYERS : butterfly layers per transform
//   NPAIRS  : butterfly pairs per layer
//   sched_state_t : scheduler FSM encoding
//   is_last_pair  : true on the final (layer, pair) of a transform
package ntt_sched_pkg;
    localparam int WID     = 32;
    localparam int AWID    = 7;
    localparam int NLAYERS = 7;
    localparam int NPAIRS  = 64;
    localparam int LWID    = 3;
    localparam int PWID    = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        ISSUE   = 3'd3,
        COLLECT = 3'd4,
        WRITE   = 3'd5
    } sched_state_t;

    // Forward order ends on the top layer, inverse order ends on layer 0.
    function automatic logic is_last_pair(input logic [LWID-1:0] layer,
                                          input logic [PWID-1:0] pair,
                                          input logic            inv);
        logic [LWID-1:0] last_layer;
        last_layer = inv ? 3'd0 : 3'(NLAYERS - 1);
        return (layer == last_layer) && (pair == PWID'(NPAIRS - 1));
    endfunction
endpackage

// File: rtl/ntt_pair_addr.sv
// ntt_pair_addr -- combinational (layer, pair) -> (A, B, zeta) mapping.
//   layer  : butterfly layer 0..6
//   pair   : pair index within the layer 0..63
//   addr_a : address of the upper operand
//   addr_b : address of the lower operand (addr_a + span)
//   zeta   : forward twiddle index (1 << layer) + group
module ntt_pair_addr
    import ntt_sched_pkg::*;
(
    input  logic [LWID-1:0] layer,
    input  logic [PWID-1:0] pair,
    output logic [AWID-1:0] addr_a,
    output logic [AWID-1:0] addr_b,
    output logic [AWID-1:0] zeta
);
    logic [AWID-1:0] len_s;
    logic [AWID-1:0] grp_s;
    logic [AWID-1:0] pair_s;

    // Span halves each layer; the group index selects which block of 2*span
    // the pair lives in, the low bits of the pair index select the offset.
    always_comb begin
        pair_s = {1'b0, pair};
        len_s  = 7'd64 >> layer;
        grp_s  = pair_s >> (3'd6 - layer);
        addr_a = (grp_s << (3'd7 - layer)) | (pair_s & (len_s - 7'd1));
        addr_b = addr_a + len_s;
        zeta   = (7'd1 << layer) + grp_s;
    end
endmodule

// File: rtl/ntt_mem_sched.sv
// ntt_mem_sched -- sequences the 448 butterflies of a 128-point NTT over a
// dual-port coefficient RAM and an external butterfly unit.
//   clk, rst            : clock, asynchronous active-low reset
//   start / busy / done : request, in-progress flag, one-cycle completion pulse
//   A1radd, B1radd      : RAM port A/B address
//   we1, we2            : RAM port A/B write enable (only in WRITE)
//   DA1in, DB1in        : RAM write data;  DA1out, DB1out : RAM read data
//   bf_valid/bf_ready, bf_a, bf_b, zeta_idx : butterfly operand channel
//   res_valid, res_a, res_b                 : butterfly result channel
// Optional build macro NTT_SCHED_INV_EN adds input inv: a start with inv=1
// walks layers 6..0 and reports mirrored twiddle indices (127 - zeta).
// All outputs are registered; they are computed from the next state so
// they line up with the state they belong to.
module ntt_mem_sched
    import ntt_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
`ifdef NTT_SCHED_INV_EN
    input  logic            inv,
`endif
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [AWID-1:0] A1radd,
    output logic [AWID-1:0] B1radd,
    output logic            we1,
    output logic            we2,
    output logic [WID-1:0]  DA1in,
    output logic [WID-1:0]  DB1in,
    input  logic [WID-1:0]  DA1out,
    input  logic [WID-1:0]  DB1out,
    output logic            bf_valid,
    input  logic            bf_ready,
    output logic [WID-1:0]  bf_a,
    output logic [WID-1:0]  bf_b,
    output logic [AWID-1:0] zeta_idx,
    input  logic            res_valid,
    input  logic [WID-1:0]  res_a,
    input  logic [WID-1:0]  res_b
);
    sched_state_t    state_q, state_d;
    logic [LWID-1:0] layer_q, layer_d;
    logic [PWID-1:0] pair_q, pair_d;
    logic            inv_q, inv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            we_q, we_d;
    logic            bf_valid_q, bf_valid_d;
    logic [AWID-1:0] addr_a_q, addr_a_d;
    logic [AWID-1:0] addr_b_q, addr_b_d;
    logic [AWID-1:0] zeta_q, zeta_d;
    logic [WID-1:0]  bf_a_q, bf_a_d;
    logic [WID-1:0]  bf_b_q, bf_b_d;
    logic [WID-1:0]  res_a_q, res_a_d;
    logic [WID-1:0]  res_b_q, res_b_d;
    logic            inv_in_s;
    logic [AWID-1:0] nxt_a_s;
    logic [AWID-1:0] nxt_b_s;
    logic [AWID-1:0] nxt_zeta_s;

`ifdef NTT_SCHED_INV_EN
    assign inv_in_s = inv;
`else
    assign inv_in_s = 1'b0;
`endif

    // Mapping is evaluated on the next (layer, pair) so it can be registered.
    ntt_pair_addr u_pair_addr (
        .layer  (layer_d),
        .pair   (pair_d),
        .addr_a (nxt_a_s),
        .addr_b (nxt_b_s),
        .zeta   (nxt_zeta_s)
    );

    // FSM next state, pair/layer stepping, data capture and output decode.
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        pair_d  = pair_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        bf_a_d  = bf_a_q;
        bf_b_d  = bf_b_q;
        res_a_d = res_a_q;
        res_b_d = res_b_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    inv_d   = inv_in_s;
                    layer_d = inv_in_s ? 3'(NLAYERS - 1) : 3'd0;
                    pair_d  = 6'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                bf_a_d  = DA1out;
                bf_b_d  = DB1out;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (bf_valid_q && bf_ready) begin
                    state_d = COLLECT;
                end else begin
                    state_d = ISSUE;
                end
            end
            COLLECT: begin
                if (res_valid) begin
                    res_a_d = res_a;
                    res_b_d = res_b;
                    state_d = WRITE;
                end else begin
                    state_d = COLLECT;
                end
            end
            WRITE: begin
                if (is_last_pair(layer_q, pair_q, inv_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                    if (pair_q == PWID'(NPAIRS - 1)) begin
                        pair_d  = 6'd0;
                        layer_d = inv_q ? (layer_q - 3'd1) : (layer_q + 3'd1);
                    end else begin
                        pair_d  = pair_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        we_d       = (state_d == WRITE);
        bf_valid_d = (state_d == ISSUE);
        if (state_d == IDLE) begin
            addr_a_d = 7'd0;
            addr_b_d = 7'd0;
            zeta_d   = 7'd0;
        end else begin
            addr_a_d = nxt_a_s;
            addr_b_d = nxt_b_s;
            zeta_d   = inv_d ? (7'd127 - nxt_zeta_s) : nxt_zeta_s;
        end
    end

    // State and output registers; reset abandons any transform in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            layer_q    <= 3'd0;
            pair_q     <= 6'd0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            bf_valid_q <= 1'b0;
            addr_a_q   <= 7'd0;
            addr_b_q   <= 7'd0;
            zeta_q     <= 7'd0;
            bf_a_q     <= 32'd0;
            bf_b_q     <= 32'd0;
            res_a_q    <= 32'd0;
            res_b_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            pair_q     <= pair_d;
            inv_q      <= inv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            bf_valid_q <= bf_valid_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            zeta_q     <= zeta_d;
            bf_a_q     <= bf_a_d;
            bf_b_q     <= bf_b_d;
            res_a_q    <= res_a_d;
            res_b_q    <= res_b_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign we1      = we_q;
    assign we2      = we_q;
    assign A1radd   = addr_a_q;
    assign B1radd   = addr_b_q;
    assign DA1in    = res_a_q;
    assign DB1in    = res_b_q;
    assign bf_valid = bf_valid_q;
    assign bf_a     = bf_a_q;
    assign bf_b     = bf_b_q;
    assign zeta_idx = zeta_q;
endmodule

// File: tb/tb_ntt_mem_sched.sv
// tb_ntt_mem_sched -- self-checking bench for ntt_mem_sched. A synchronous
// dual-port RAM and a butterfly responder surround the DUT; a reference model
// (classic nested NTT loops over span/group) predicts pair order, operands
// and final RAM contents.
module tb_ntt_mem_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, we1, we2, bf_valid;
    logic [6:0]  A1radd, B1radd, zeta_idx;
    logic [31:0] DA1in, DB1in, bf_a, bf_b;
    logic [31:0] DA1out = 32'd0;
    logic [31:0] DB1out = 32'd0;
    logic        bf_ready = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_a = 32'd0;
    logic [31:0] res_b = 32'd0;
`ifdef NTT_SCHED_INV_EN
    logic        inv = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem       [128];
    logic [31:0] load_img  [128];
    logic [31:0] model_mem [128];
    logic        load_req = 1'b0;
    logic [6:0]  exp_a [448];
    logic [6:0]  exp_b [448];
    logic [6:0]  exp_z [448];
    logic [6:0]  obs_a [448];
    logic [6:0]  obs_b [448];
    logic [6:0]  obs_z [448];

    ntt_mem_sched dut (
        .clk       (clk),
        .rst       (rst),
`ifdef NTT_SCHED_INV_EN
        .inv       (inv),
`endif
        .start     (start),
        .busy      (busy),
        .done      (done),
        .A1radd    (A1radd),
        .B1radd    (B1radd),
        .we1       (we1),
        .we2       (we2),
        .DA1in     (DA1in),
        .DB1in     (DB1in),
        .DA1out    (DA1out),
        .DB1out    (DB1out),
        .bf_valid  (bf_valid),
        .bf_ready  (bf_ready),
        .bf_a      (bf_a),
        .bf_b      (bf_b),
        .zeta_idx  (zeta_idx),
        .res_valid (res_valid),
        .res_a     (res_a),
        .res_b     (res_b)
    );

    always #5 clk = ~clk;

    // Coefficient RAM: registered read, write on enable, bulk preload.
    always @(posedge clk) begin
        if (load_req) begin
            mem <= load_img;
        end else begin
            if (we1) mem[A1radd] <= DA1in;
            if (we2) mem[B1radd] <= DB1in;
        end
        DA1out <= mem[A1radd];
        DB1out <= mem[B1radd];
    end

    // Hard stop in case the DUT wedges somewhere no cycle budget covers.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time expired, want completion");
        $fatal(1, "watchdog");
    end

    // Expected pair order: span halves per layer, groups ascend, twiddle
    // index increments once per group across the whole transform.
    task automatic build_pairs();
        int k;
        int z;
        k = 0;
        z = 1;
        for (int len = 64; len >= 1; len = len / 2) begin
            for (int st = 0; st < 128; st = st + 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    exp_a[k] = 7'(j);
                    exp_b[k] = 7'(j + len);
                    exp_z[k] = 7'(z);
                    k++;
                end
                z++;
            end
        end
    endtask

    task automatic preload(input bit ident);
        for (int i = 0; i < 128; i++) begin
            load_img[i]  = ident ? 32'(i) : $urandom;
            model_mem[i] = load_img[i];
        end
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Runs one transform; stress adds random backpressure, result latency,
    // stray res_valid pulses and start while busy. Returns in the done cycle.
    task automatic run_transform(input bit ident, input bit stress, input bit record);
        int cyc, busy_cyc, wr_k, hs_k, cnt, rk, hk;
        bit pending, is_read, done_seen, stalled;
        logic [31:0] ra, rb, ma, mb, sa, sb;
        logic [6:0]  sz, sadr;
        cyc = 0; busy_cyc = 0; wr_k = 0; hs_k = 0; cnt = 0;
        pending = 1'b0; is_read = 1'b1; done_seen = 1'b0; stalled = 1'b0;
        ra = 32'd0; rb = 32'd0; sa = 32'd0; sb = 32'd0; sz = 7'd0; sadr = 7'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done_seen && cyc < 20000) begin
            rk = (wr_k < 448) ? wr_k : 447;
            hk = (hs_k < 448) ? hs_k : 447;
            if (busy === 1'b1) busy_cyc++;
            if (is_read && busy === 1'b1) begin
                if (record) begin
                    obs_a[rk] = A1radd; obs_b[rk] = B1radd; obs_z[rk] = zeta_idx;
                end
                n_cmp++;
                if ({A1radd, B1radd, zeta_idx} !== {exp_a[rk], exp_b[rk], exp_z[rk]}) begin
                    n_fail++;
                    $display("FAIL read_map k=%0d: got A=%0d B=%0d z=%0d, want A=%0d B=%0d z=%0d",
                             wr_k, A1radd, B1radd, zeta_idx, exp_a[rk], exp_b[rk], exp_z[rk]);
                end
            end
            is_read = 1'b0;
            if (we1 === 1'b1 || we2 === 1'b1) begin
                n_cmp++;
                if ({we1, we2, A1radd, B1radd, DA1in, DB1in} !==
                    {2'b11, exp_a[rk], exp_b[rk], model_mem[exp_a[rk]], model_mem[exp_b[rk]]} || wr_k >= 448) begin
                    n_fail++;
                    $display("FAIL write k=%0d: got we=%b%b A=%0d B=%0d da=%h db=%h, want we=11 A=%0d B=%0d da=%h db=%h",
                             wr_k, we1, we2, A1radd, B1radd, DA1in, DB1in, exp_a[rk], exp_b[rk],
                             model_mem[exp_a[rk]], model_mem[exp_b[rk]]);
                end
                wr_k++;
                is_read = 1'b1;
            end
            if (stalled) begin
                n_cmp++;
                if ({bf_valid, bf_a, bf_b, zeta_idx, A1radd} !== {1'b1, sa, sb, sz, sadr}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b a=%h b=%h z=%0d A=%0d, want v=1 a=%h b=%h z=%0d A=%0d",
                             bf_valid, bf_a, bf_b, zeta_idx, A1radd, sa, sb, sz, sadr);
                end
            end
            stalled = 1'b0;
            if (done === 1'b1) begin
                done_seen = 1'b1;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_busy: got busy=%b in done cycle, want 0", busy);
                end
            end else begin
                res_valid = 1'b0;
                if (pending) begin
                    if (cnt == 0) begin
                        res_valid = 1'b1; res_a = ra; res_b = rb; pending = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (stress && $urandom_range(0, 3) == 0) begin
                    res_valid = 1'b1; res_a = $urandom; res_b = $urandom;
                end
                if (bf_valid === 1'b1) begin
                    bf_ready = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (bf_ready) begin
                        ma = model_mem[exp_a[hk]];
                        mb = model_mem[exp_b[hk]];
                        n_cmp++;
                        if ({bf_a, bf_b, zeta_idx} !== {ma, mb, exp_z[hk]} || hs_k >= 448) begin
                            n_fail++;
                            $display("FAIL operands k=%0d: got a=%h b=%h z=%0d, want a=%h b=%h z=%0d",
                                     hs_k, bf_a, bf_b, zeta_idx, ma, mb, exp_z[hk]);
                        end
                        if (ident) begin
                            ra = ma; rb = mb;
                        end else begin
                            ra = ma + mb; rb = ma - mb + {25'd0, exp_z[hk]};
                        end
                        model_mem[exp_a[hk]] = ra;
                        model_mem[exp_b[hk]] = rb;
                        pending = 1'b1;
                        cnt = stress ? int'($urandom_range(0, 3)) : 0;
                        hs_k++;
                    end else begin
                        stalled = 1'b1;
                        sa = bf_a; sb = bf_b; sz = zeta_idx; sadr = A1radd;
                    end
                end else begin
                    bf_ready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                start = stress ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        res_valid = 1'b0;
        n_cmp++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL run_timeout: got no done in %0d cycles, want done", cyc);
        end
        if (!stress) begin
            n_cmp++;
            if (busy_cyc != 2240) begin
                n_fail++;
                $display("FAIL busy_cycles: got %0d, want 2240", busy_cyc);
            end
        end
        n_cmp++;
        if (wr_k != 448 || hs_k != 448) begin
            n_fail++;
            $display("FAIL pair_count: got writes=%0d handshakes=%0d, want 448/448", wr_k, hs_k);
        end
        for (int i = 0; i < 128; i++) begin
            n_cmp++;
            if (mem[i] !== model_mem[i]) begin
                n_fail++;
                $display("FAIL ram[%0d]: got %h, want %h", i, mem[i], model_mem[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, we1, we2, bf_valid} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctl: got busy/done/we1/we2/bf_valid=%b%b%b%b%b, want 00000", busy, done, we1, we2, bf_valid);
        end
        n_cmp++;
        if ({A1radd, B1radd, zeta_idx} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got A=%0d B=%0d z=%0d, want 0 0 0", A1radd, B1radd, zeta_idx);
        end
        n_cmp++;
        if ({DA1in, DB1in, bf_a, bf_b} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got da=%h db=%h a=%h b=%h, want 0", DA1in, DB1in, bf_a, bf_b);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, we1} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_start: got busy=%b we1=%b, want 0 0", busy, we1);
        end
    endtask

    task automatic test_identity_run();
        preload(1'b1);
        run_transform(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b after done cycle, want 0 0", done, busy);
        end
    endtask

    task automatic test_layer0_map();
        n_cmp++;
        if ({obs_a[0], obs_b[0], obs_z[0]} !== {7'd0, 7'd64, 7'd1}) begin
            n_fail++;
            $display("FAIL l0_p0: got A=%0d B=%0d z=%0d, want 0 64 1", obs_a[0], obs_b[0], obs_z[0]);
        end
        n_cmp++;
        if ({obs_a[63], obs_b[63]} !== {7'd63, 7'd127}) begin
            n_fail++;
            $display("FAIL l0_p63: got A=%0d B=%0d, want 63 127", obs_a[63], obs_b[63]);
        end
    endtask

    task automatic test_layer6_map();
        n_cmp++;
        if ({obs_a[389], obs_b[389], obs_z[389]} !== {7'd10, 7'd11, 7'd69}) begin
            n_fail++;
            $display("FAIL l6_p5: got A=%0d B=%0d z=%0d, want 10 11 69", obs_a[389], obs_b[389], obs_z[389]);
        end
    endtask

    task automatic test_random_run();
        preload(1'b0);
        run_transform(1'b0, 1'b1, 1'b0);
    endtask

    // Starts the next transform in the very cycle done is high.
    task automatic test_back_to_back();
        run_transform(1'b0, 1'b1, 1'b0);
        run_transform(1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [31:0] sa, sb;
        logic [6:0]  sz, sadr;
        preload(1'b1);
        bf_ready = 1'b0;
        res_valid = 1'b0;
        start = 1'b1;                    // held high for the whole pair
        @(negedge clk);                  // READ
        @(negedge clk);                  // WAIT
        @(negedge clk);                  // ISSUE, stalled
        n_cmp++;
        if ({bf_valid, bf_a, bf_b, zeta_idx} !== {1'b1, 32'd0, 32'd64, 7'd1}) begin
            n_fail++;
            $display("FAIL bp_issue: got v=%b a=%h b=%h z=%0d, want 1 0 40 1", bf_valid, bf_a, bf_b, zeta_idx);
        end
        sa = bf_a; sb = bf_b; sz = zeta_idx; sadr = A1radd;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({bf_valid, bf_a, bf_b, zeta_idx, A1radd} !== {1'b1, sa, sb, sz, sadr}) begin
                n_fail++;
                $display("FAIL bp_hold: got v=%b a=%h b=%h z=%0d A=%0d, want 1 %h %h %0d %0d",
                         bf_valid, bf_a, bf_b, zeta_idx, A1radd, sa, sb, sz, sadr);
            end
        end
        bf_ready = 1'b1;
        @(negedge clk);                  // COLLECT
        bf_ready = 1'b0;
        n_cmp++;
        if ({bf_valid, we1, we2} !== 3'b000) begin
            n_fail++;
            $display("FAIL bp_collect: got v=%b we=%b%b, want 0 00", bf_valid, we1, we2);
        end
        res_valid = 1'b1; res_a = 32'hCAFE_0001; res_b = 32'hCAFE_0002;
        @(negedge clk);                  // WRITE
        res_valid = 1'b0;
        n_cmp++;
        if ({we1, we2, A1radd, B1radd, DA1in, DB1in} !== {2'b11, 7'd0, 7'd64, 32'hCAFE_0001, 32'hCAFE_0002}) begin
            n_fail++;
            $display("FAIL bp_write: got we=%b%b A=%0d B=%0d da=%h db=%h, want 11 0 64 cafe0001 cafe0002",
                     we1, we2, A1radd, B1radd, DA1in, DB1in);
        end
        @(negedge clk);                  // READ of pair 1: start was ignored
        n_cmp++;
        if ({busy, A1radd, B1radd, zeta_idx} !== {1'b1, 7'd1, 7'd65, 7'd1}) begin
            n_fail++;
            $display("FAIL start_ignored: got busy=%b A=%0d B=%0d z=%0d, want 1 1 65 1", busy, A1radd, B1radd, zeta_idx);
        end
        start = 1'b0;
        n_cmp++;
        if ({mem[0], mem[64]} !== {32'hCAFE_0001, 32'hCAFE_0002}) begin
            n_fail++;
            $display("FAIL bp_ram: got m0=%h m64=%h, want cafe0001 cafe0002", mem[0], mem[64]);
        end
        @(negedge clk);                  // WAIT
        @(negedge clk);                  // ISSUE
        bf_ready = 1'b1;
        @(negedge clk);                  // COLLECT
        bf_ready = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, we1, we2, bf_valid, A1radd, B1radd, zeta_idx} !== 26'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b done=%b we=%b%b v=%b A=%0d B=%0d z=%0d, want all 0",
                     busy, done, we1, we2, bf_valid, A1radd, B1radd, zeta_idx);
        end
        res_valid = 1'b1; res_a = 32'hDEAD_0001; res_b = 32'hDEAD_0002;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, we1, we2} !== 3'b000) begin
                n_fail++;
                $display("FAIL post_reset: got busy=%b we=%b%b, want 0 00", busy, we1, we2);
            end
        end
        res_valid = 1'b0;
        n_cmp++;
        if ({mem[1], mem[65]} !== {32'd1, 32'd65}) begin
            n_fail++;
            $display("FAIL no_partial_write: got m1=%h m65=%h, want 1 41", mem[1], mem[65]);
        end
    endtask

    initial begin
        build_pairs();
        test_reset();
        test_identity_run();
        test_layer0_map();
        test_layer6_map();
        test_random_run();
        test_back_to_back();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
